// File: rtl/nx_stream_arbiter_pkg.sv
// Shared message types and direction codes for the nx stream fabric.
package nx_stream_arbiter_pkg;

  typedef struct packed {
    logic [3:0] kind;
    logic [7:0] payload;
  } nx_message_t;

  localparam int NX_MSG_W = $bits(nx_message_t);

  localparam logic [1:0] NX_DIRX_NORTH = 2'd0;
  localparam logic [1:0] NX_DIRX_EAST  = 2'd1;
  localparam logic [1:0] NX_DIRX_SOUTH = 2'd2;
  localparam logic [1:0] NX_DIRX_WEST  = 2'd3;

  typedef enum logic [1:0] {
    ROUND_ROBIN,
    PREFER_LOW,
    PREFER_HIGH
  } nx_arb_scheme_t;

endpackage

// File: rtl/nx_msg_fifo.sv
// Small synchronous FIFO; pointers carry an extra wrap bit to split full from empty.
module nx_msg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][WIDTH-1:0]  mem_q, mem_d;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // full blocks push even when the same cycle pops
    if (push_i && !full_o) begin
      mem_d[wr_ptr_q[AW-1:0]] = data_i;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_i && !empty_o) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/nx_stream_arbiter.sv
// Merges CHANNELS buffered message streams into one registered output stream,
// tagging each output with its source channel.
module nx_stream_arbiter
  import nx_stream_arbiter_pkg::*;
#(
  parameter int    CHANNELS   = 4,
  parameter int    FIFO_DEPTH = 2,
  parameter string ARB_SCHEME = "round_robin",
  parameter int    IDX_W      = $clog2(CHANNELS)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [CHANNELS-1:0][NX_MSG_W-1:0]  stream_data_i,
  input  logic [CHANNELS-1:0][1:0]           stream_dir_i,
  input  logic [CHANNELS-1:0]                stream_valid_i,
  output logic [CHANNELS-1:0]                stream_ready_o,
  output logic [NX_MSG_W-1:0]                comb_data_o,
  output logic [1:0]                         comb_dir_o,
  output logic [IDX_W-1:0]                   comb_src_o,
  output logic                               comb_valid_o,
  input  logic                               comb_ready_i,
  output logic                               idle_o
);
  localparam nx_arb_scheme_t SCHEME =
    (ARB_SCHEME == "prefer_low")  ? PREFER_LOW  :
    (ARB_SCHEME == "prefer_high") ? PREFER_HIGH : ROUND_ROBIN;

  if (CHANNELS < 2 || CHANNELS > 16) begin : g_bad_channels
    $fatal(1, "nx_stream_arbiter: CHANNELS must be 2..16");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "nx_stream_arbiter: FIFO_DEPTH must be a power of 2, >= 2");
  end
  if (ARB_SCHEME != "round_robin" && ARB_SCHEME != "prefer_low" &&
      ARB_SCHEME != "prefer_high") begin : g_bad_scheme
    $fatal(1, "nx_stream_arbiter: unsupported ARB_SCHEME");
  end

  logic [CHANNELS-1:0]                fifo_full, fifo_empty, fifo_pop;
  logic [CHANNELS-1:0][NX_MSG_W+1:0]  fifo_dout;

  logic                 slot_free, grant_found, grant_vld;
  logic [IDX_W-1:0]     grant_idx, rr_cand;

  logic                 comb_valid_q, comb_valid_d;
  logic [NX_MSG_W-1:0]  comb_data_q, comb_data_d;
  logic [1:0]           comb_dir_q, comb_dir_d;
  logic [IDX_W-1:0]     comb_src_q, comb_src_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    nx_msg_fifo #(.WIDTH(NX_MSG_W + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (stream_valid_i[c]),
      .pop_i   (fifo_pop[c]),
      .data_i  ({stream_dir_i[c], stream_data_i[c]}),
      .data_o  (fifo_dout[c]),
      .full_o  (fifo_full[c]),
      .empty_o (fifo_empty[c])
    );
    assign fifo_pop[c] = grant_vld && (grant_idx == IDX_W'(c));
  end

  assign stream_ready_o = ~fifo_full;

  always_comb begin
    slot_free   = !comb_valid_q || comb_ready_i;
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_cand     = '0;
    case (SCHEME)
      PREFER_LOW: begin
        for (int i = 0; i < CHANNELS; i++)
          if (!grant_found && !fifo_empty[i]) begin
            grant_found = 1'b1;
            grant_idx   = IDX_W'(i);
          end
      end
      PREFER_HIGH: begin
        for (int i = CHANNELS - 1; i >= 0; i--)
          if (!grant_found && !fifo_empty[i]) begin
            grant_found = 1'b1;
            grant_idx   = IDX_W'(i);
          end
      end
      default: begin
        // walk last_grant+1 .. last_grant+CHANNELS, wrapping below CHANNELS
        for (int i = 1; i <= CHANNELS; i++) begin
          rr_cand = IDX_W'((int'(last_grant_q) + i) % CHANNELS);
          if (!grant_found && !fifo_empty[rr_cand]) begin
            grant_found = 1'b1;
            grant_idx   = rr_cand;
          end
        end
      end
    endcase
    grant_vld = slot_free && grant_found;

    comb_valid_d = comb_valid_q;
    comb_data_d  = comb_data_q;
    comb_dir_d   = comb_dir_q;
    comb_src_d   = comb_src_q;
    last_grant_d = last_grant_q;
    if (slot_free) begin
      comb_valid_d = grant_found;
      if (grant_found) begin
        {comb_dir_d, comb_data_d} = fifo_dout[grant_idx];
        comb_src_d   = grant_idx;
        last_grant_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      comb_valid_q <= 1'b0;
      comb_data_q  <= '0;
      comb_dir_q   <= NX_DIRX_NORTH;
      comb_src_q   <= '0;
      last_grant_q <= IDX_W'(CHANNELS - 1);
    end else begin
      comb_valid_q <= comb_valid_d;
      comb_data_q  <= comb_data_d;
      comb_dir_q   <= comb_dir_d;
      comb_src_q   <= comb_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign comb_valid_o = comb_valid_q;
  assign comb_data_o  = comb_data_q;
  assign comb_dir_o   = comb_dir_q;
  assign comb_src_o   = comb_src_q;
  assign idle_o       = (&fifo_empty) && !comb_valid_q;

endmodule

// File: tb/tb_nx_stream_arbiter.sv
// Directed bench for nx_stream_arbiter: round-robin instance with a per-channel
// scoreboard, plus a prefer_low instance for priority behaviour.
module tb_nx_stream_arbiter;
  import nx_stream_arbiter_pkg::*;

  localparam int CH = 4;
  localparam int MW = NX_MSG_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [CH-1:0][MW-1:0] s_data;
  logic [CH-1:0][1:0]    s_dir;
  logic [CH-1:0]         s_valid, s_ready;
  logic [MW-1:0]         c_data;
  logic [1:0]            c_dir, c_src;
  logic                  c_valid, c_ready, idle;

  logic [CH-1:0][MW-1:0] p_data;
  logic [CH-1:0][1:0]    p_dir;
  logic [CH-1:0]         p_valid, p_ready;
  logic [MW-1:0]         pc_data;
  logic [1:0]            pc_dir, pc_src;
  logic                  pc_valid, pc_ready, p_idle;

  nx_stream_arbiter #(.CHANNELS(CH), .FIFO_DEPTH(2), .ARB_SCHEME("round_robin")) u_rr (
    .clk_i(clk), .rst_i(rst_n),
    .stream_data_i(s_data), .stream_dir_i(s_dir), .stream_valid_i(s_valid),
    .stream_ready_o(s_ready),
    .comb_data_o(c_data), .comb_dir_o(c_dir), .comb_src_o(c_src),
    .comb_valid_o(c_valid), .comb_ready_i(c_ready), .idle_o(idle)
  );

  nx_stream_arbiter #(.CHANNELS(CH), .FIFO_DEPTH(2), .ARB_SCHEME("prefer_low")) u_pl (
    .clk_i(clk), .rst_i(rst_n),
    .stream_data_i(p_data), .stream_dir_i(p_dir), .stream_valid_i(p_valid),
    .stream_ready_o(p_ready),
    .comb_data_o(pc_data), .comb_dir_o(pc_dir), .comb_src_o(pc_src),
    .comb_valid_o(pc_valid), .comb_ready_i(pc_ready), .idle_o(p_idle)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [MW+1:0] exp_q [CH][$];
  int  seq [CH];
  int  acc_cnt [CH];
  int  src_cnt [CH];
  bit  auto_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data();
    for (int c = 0; c < CH; c++) begin
      s_data[c] = {4'(c), 8'(seq[c])};
      s_dir[c]  = 2'(seq[c]);
    end
  endtask

  // Record accepts and consumed outputs just before the edge, then step one cycle.
  task automatic tick();
    logic [MW+1:0] e;
    int s;
    @(negedge clk);
    if (rst_n) begin
      for (int c = 0; c < CH; c++)
        if (s_valid[c] && s_ready[c]) begin
          exp_q[c].push_back({s_dir[c], s_data[c]});
          acc_cnt[c]++;
          seq[c]++;
        end
      if (c_valid && c_ready) begin
        s = int'(c_src);
        check("sb_has_entry", 32'(exp_q[s].size() != 0), 1);
        if (exp_q[s].size() != 0) begin
          e = exp_q[s].pop_front();
          check("sb_data", 32'({c_dir, c_data}), 32'(e));
        end
      end
    end
    @(posedge clk);
    #1;
    if (auto_data) set_data();
  endtask

  task automatic assert_reset(input int n);
    rst_n   = 1'b0;
    s_valid = '0;
    p_valid = '0;
    for (int c = 0; c < CH; c++) begin
      exp_q[c].delete();
      acc_cnt[c] = 0;
    end
    repeat (n) tick();
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    s_valid = '0;
    c_ready = 1'b1;
    tick();
    while (!(idle && !c_valid) && budget < 40) begin
      tick();
      budget++;
    end
    check({tag, "_idle"}, 32'(idle), 1);
    for (int c = 0; c < CH; c++) check({tag, "_left"}, exp_q[c].size(), 0);
  endtask

  initial begin
    s_valid = '0; s_data = '0; s_dir = '0; c_ready = 1'b1;
    p_valid = '0; p_dir = '0; pc_ready = 1'b1;
    for (int c = 0; c < CH; c++) begin
      seq[c] = 0;
      p_data[c] = {4'(c), 8'h55};
    end
    auto_data = 1'b0;
    #1;

    // reset state, then one message on channel 2
    assert_reset(3);
    check("rst_valid", 32'(c_valid), 0);
    check("rst_data",  32'(c_data), 0);
    check("rst_dir",   32'(c_dir), 32'(NX_DIRX_NORTH));
    check("rst_src",   32'(c_src), 0);
    check("rst_idle",  32'(idle), 1);
    check("rst_ready", 32'(s_ready), 32'hF);
    rst_n = 1'b1;
    c_ready = 1'b1;
    s_data[2] = 12'h0A5;
    s_dir[2]  = NX_DIRX_EAST;
    s_valid   = 4'b0100;
    tick();
    s_valid = '0;
    check("t1_lat1_valid", 32'(c_valid), 0);
    tick();
    check("t1_valid", 32'(c_valid), 1);
    check("t1_data",  32'(c_data), 32'h0A5);
    check("t1_dir",   32'(c_dir), 32'(NX_DIRX_EAST));
    check("t1_src",   32'(c_src), 2);
    tick();
    check("t1_drop", 32'(c_valid), 0);
    check("t1_idle", 32'(idle), 1);

    // round-robin fairness
    assert_reset(1);
    rst_n = 1'b1;
    auto_data = 1'b1;
    set_data();
    for (int c = 0; c < CH; c++) src_cnt[c] = 0;
    s_valid = 4'hF;
    tick();
    for (int i = 0; i < 400; i++) begin
      tick();
      check("rr_valid", 32'(c_valid), 1);
      check("rr_src", 32'(c_src), 32'(i % CH));
      src_cnt[c_src]++;
    end
    for (int c = 0; c < CH; c++) check("rr_count", src_cnt[c], 100);
    drain("rr_drain");

    // backpressure
    assert_reset(1);
    rst_n = 1'b1;
    c_ready = 1'b0;
    s_valid = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 1) begin
        check("bp_valid", 32'(c_valid), 1);
        check("bp_src", 32'(c_src), 0);
        check("bp_hold", 32'({c_dir, c_data}), 32'(exp_q[0][0]));
      end
    end
    check("bp_ready", 32'(s_ready), 0);
    check("bp_acc0", acc_cnt[0], 3);
    for (int c = 1; c < CH; c++) check("bp_acc", acc_cnt[c], 2);
    drain("bp_drain");

    // full FIFO popped and pushed in the same cycle
    assert_reset(1);
    rst_n = 1'b1;
    c_ready = 1'b0;
    s_valid = 4'b0010;
    repeat (3) tick();
    check("full_rdy0", 32'(s_ready[1]), 0);
    c_ready = 1'b1;
    check("full_rdy0_pop", 32'(s_ready[1]), 0);
    tick();
    s_valid = '0;
    check("full_rdy1", 32'(s_ready[1]), 1);
    check("full_acc", acc_cnt[1], 3);
    check("full_src", 32'(c_src), 1);
    check("full_data", 32'({c_dir, c_data}), 32'(exp_q[1][0]));
    drain("full_drain");

    // reset with messages buffered
    assert_reset(1);
    rst_n = 1'b1;
    c_ready = 1'b0;
    s_valid = 4'b0011;
    repeat (3) tick();
    assert_reset(1);
    check("mrst_valid", 32'(c_valid), 0);
    check("mrst_idle",  32'(idle), 1);
    check("mrst_ready", 32'(s_ready), 32'hF);
    rst_n = 1'b1;
    c_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("mrst_quiet", 32'(c_valid), 0);
    end

    // prefer_low on the second instance
    pc_ready = 1'b1;
    p_valid = 4'b1001;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("pl_valid", 32'(pc_valid), 1);
      check("pl_src0", 32'(pc_src), 0);
    end
    p_valid[0] = 1'b0;
    tick();
    check("pl_last0", 32'(pc_src), 0);
    tick();
    check("pl_src3", 32'(pc_src), 3);
    check("pl_data3", 32'(pc_data), 32'h355);
    p_valid = '0;
    tick();
    check("pl_src3b", 32'(pc_src), 3);
    tick();
    check("pl_done", 32'(pc_valid), 0);
    check("pl_idle", 32'(p_idle), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
